// File: rtl/uart_note_sequencer_pkg.sv
// Shared constants for the note sequencer: FSM encoding and the pitch
// half-period table (clocks at 25 MHz, C4 at index 0 up to D#5 at 15).
package uart_note_sequencer_pkg;

    localparam int CLK_HZ = 25_000_000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;

    localparam int HALF_W = 16;
    typedef logic [HALF_W-1:0] half_t;

    // Index 0 is never played: pitch 0 means rest.
    function automatic half_t pitch_half(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'd47778;
            4'd1:    return 16'd45097;
            4'd2:    return 16'd42566;
            4'd3:    return 16'd40176;
            4'd4:    return 16'd37921;
            4'd5:    return 16'd35793;
            4'd6:    return 16'd33784;
            4'd7:    return 16'd31888;
            4'd8:    return 16'd30098;
            4'd9:    return 16'd28409;
            4'd10:   return 16'd26815;
            4'd11:   return 16'd25310;
            4'd12:   return 16'd23889;
            4'd13:   return 16'd22548;
            4'd14:   return 16'd21283;
            default: return 16'd20088;
        endcase
    endfunction

endpackage

// File: rtl/uart_note_sequencer_ram.sv
// Note buffer: DEPTH x 8, one write port, registered read port.
module note_ram #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_note_sequencer.sv
// Note sequencer: buffers note bytes and plays them as a square wave,
// one-shot or looping, with manual stepping while idle.
module uart_note_sequencer
    import uart_note_sequencer_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int NOTE_CLKS   = 6_250_000,
    parameter  int PITCH_SHIFT = 0,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Wr_DV,
    input  logic [7:0]    i_Wr_Byte,
    input  logic          i_Play,
    input  logic          i_Loop,
    input  logic          i_Step,
    input  logic          i_Clear,
    output logic          o_Tone,
    output logic [AW-1:0] o_Addr,
    output logic [7:0]    o_Note,
    output logic [AW:0]   o_Count,
    output logic          o_Full,
    output logic          o_Overflow,
    output logic          o_Busy,
    output logic          o_Done
);

    localparam int DW = $clog2(15 * NOTE_CLKS + 1);

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] dur_cnt, dur_load;
    half_t         half_cnt, half_fetch, half_play;
    logic [3:0]    note_pitch, dur_units;
    logic          last, wr_en;

    assign o_Full   = (o_Count == (AW+1)'(DEPTH));
    assign o_Busy   = (state != ST_IDLE);
    assign last     = ({1'b0, o_Addr} == o_Count - (AW+1)'(1));
    assign wr_en    = i_Rst_L && !i_Clear && i_Wr_DV && !o_Full;

    assign dur_units  = (o_Note[7:4] == 4'd0) ? 4'd1 : o_Note[7:4];
    assign dur_load   = DW'(dur_units) * DW'(NOTE_CLKS);
    assign half_fetch = pitch_half(o_Note[3:0]) >> PITCH_SHIFT;
    assign half_play  = pitch_half(note_pitch) >> PITCH_SHIFT;

    // Reads follow the next address so FETCH sees the note in one cycle.
    note_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (i_Clk),
        .wr_en   (wr_en),
        .wr_addr (o_Count[AW-1:0]),
        .wr_data (i_Wr_Byte),
        .rd_addr (addr_nxt),
        .rd_data (o_Note)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = o_Addr;
        if (!i_Rst_L || i_Clear) begin
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_Play && o_Count != '0) begin
                        state_nxt = ST_FETCH;
                        addr_nxt  = '0;
                    end else if (i_Step && o_Count != '0) begin
                        addr_nxt = last ? '0 : o_Addr + AW'(1);
                    end
                end
                ST_FETCH: begin
                    state_nxt = i_Play ? ST_PLAY : ST_IDLE;
                end
                ST_PLAY: begin
                    if (!i_Play) begin
                        state_nxt = ST_IDLE;
                    end else if (dur_cnt == DW'(1)) begin
                        if (!last) begin
                            state_nxt = ST_FETCH;
                            addr_nxt  = o_Addr + AW'(1);
                        end else if (i_Loop) begin
                            state_nxt = ST_FETCH;
                            addr_nxt  = '0;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state      <= ST_IDLE;
            o_Addr     <= '0;
            o_Count    <= '0;
            o_Overflow <= 1'b0;
            o_Done     <= 1'b0;
            o_Tone     <= 1'b0;
            dur_cnt    <= '0;
            half_cnt   <= '0;
            note_pitch <= '0;
        end else begin
            state  <= state_nxt;
            o_Addr <= addr_nxt;
            o_Done <= 1'b0;
            if (i_Clear) begin
                o_Count    <= '0;
                o_Overflow <= 1'b0;
                o_Tone     <= 1'b0;
            end else begin
                if (i_Wr_DV) begin
                    if (o_Full) o_Overflow <= 1'b1;
                    else        o_Count    <= o_Count + (AW+1)'(1);
                end
                case (state)
                    ST_FETCH: begin
                        note_pitch <= o_Note[3:0];
                        dur_cnt    <= dur_load;
                        half_cnt   <= half_fetch;
                        o_Tone     <= 1'b0;
                    end
                    ST_PLAY: begin
                        if (state_nxt != ST_PLAY) begin
                            o_Tone <= 1'b0;
                            o_Done <= (state_nxt == ST_IDLE) && i_Play;
                        end else begin
                            dur_cnt <= dur_cnt - DW'(1);
                            if (note_pitch == 4'd0) begin
                                o_Tone <= 1'b0;
                            end else if (half_cnt == half_t'(1)) begin
                                o_Tone   <= ~o_Tone;
                                half_cnt <= half_play;
                            end else begin
                                half_cnt <= half_cnt - half_t'(1);
                            end
                        end
                    end
                    default: o_Tone <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_note_sequencer.sv
// Randomised and directed bench for uart_note_sequencer against a
// cycle-level behavioural model of the note player.
module tb_uart_note_sequencer;

    localparam int DEPTH = 4;
    localparam int NC    = 10;
    localparam int SH    = 12;
    localparam int AW    = 2;

    logic          clk = 0, rst_n = 0;
    logic          wr = 0, play = 0, loop = 0, step = 0, clr = 0;
    logic [7:0]    wbyte = 0;
    logic          tone, full, ovf, busy, done;
    logic [AW-1:0] addr;
    logic [7:0]    note;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    uart_note_sequencer #(.DEPTH(DEPTH), .NOTE_CLKS(NC), .PITCH_SHIFT(SH)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr), .i_Wr_Byte(wbyte),
        .i_Play(play), .i_Loop(loop), .i_Step(step), .i_Clear(clr),
        .o_Tone(tone), .o_Addr(addr), .o_Note(note), .o_Count(count),
        .o_Full(full), .o_Overflow(ovf), .o_Busy(busy), .o_Done(done)
    );

    int n_vec = 0, n_err = 0;

    // Half periods of C4..D#5 at 25 MHz, scaled down by 2**SH.
    int half_tab [16] = '{47778, 45097, 42566, 40176, 37921, 35793, 33784,
                          31888, 30098, 28409, 26815, 25310, 23889, 22548,
                          21283, 20088};

    // Model: mode 0 waiting, 1 loading a note, 2 sounding a note.
    int m_mode = 0, m_addr = 0, m_count = 0, m_left = 0, m_k = 0;
    int m_pitch = 0, m_note = 0;
    bit m_ovf = 0, m_done = 0, m_note_ok = 0;
    int m_mem [DEPTH];
    bit m_val [DEPTH];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int c, dur;
        bit lst;
        m_done = 0;
        if (!rst_n) begin
            m_mode = 0; m_addr = 0; m_count = 0; m_ovf = 0;
            m_note_ok = m_val[0]; m_note = m_mem[0];
            return;
        end
        c = m_count;
        lst = (m_addr == c - 1);
        if (clr) begin
            m_mode = 0; m_addr = 0; m_count = 0; m_ovf = 0;
        end else begin
            case (m_mode)
                0: if (play && c != 0) begin
                       m_mode = 1; m_addr = 0;
                   end else if (step && c != 0) begin
                       m_addr = lst ? 0 : m_addr + 1;
                   end
                1: if (!play) m_mode = 0;
                   else begin
                       m_pitch = m_mem[m_addr] % 16;
                       dur = m_mem[m_addr] / 16;
                       if (dur == 0) dur = 1;
                       m_left = dur * NC; m_k = 0; m_mode = 2;
                   end
                default:
                   if (!play) m_mode = 0;
                   else if (m_left == 1) begin
                       if (!lst) begin m_mode = 1; m_addr++; end
                       else if (loop) begin m_mode = 1; m_addr = 0; end
                       else begin m_mode = 0; m_done = 1; end
                   end else begin
                       m_left--; m_k++;
                   end
            endcase
        end
        m_note_ok = m_val[m_addr];
        m_note = m_mem[m_addr];
        if (!clr && wr) begin
            if (c < DEPTH) begin
                m_mem[c] = wbyte; m_val[c] = 1; m_count = c + 1;
            end else m_ovf = 1;
        end
    endtask

    task automatic tick();
        int et;
        @(posedge clk);
        model_step();
        #1;
        et = (m_mode == 2 && m_pitch != 0) ? ((m_k / (half_tab[m_pitch] >> SH)) % 2) : 0;
        check("tone", tone, et);
        check("addr", addr, m_addr);
        check("count", count, m_count);
        check("full", full, int'(m_count == DEPTH));
        check("ovf", ovf, m_ovf);
        check("busy", busy, int'(m_mode != 0));
        check("done", done, m_done);
        if (m_note_ok) check("note", note, m_note);
        wr = 0; step = 0; clr = 0;
    endtask

    task automatic put(input logic [7:0] b);
        wr = 1; wbyte = b; tick();
    endtask

    task automatic do_clear();
        play = 0; clr = 1; tick();
    endtask

    int busy_n, done_n, tone_n;
    int hold [DEPTH];
    int seq [$];
    logic [7:0] rb [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_val[i] = 0; end
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_tone", tone, 0);
        check("rst_addr", addr, 0);
        rst_n = 1;
        tick();

        // three notes, one shot
        put(8'h11); put(8'h22); put(8'h33);
        busy_n = 0; done_n = 0;
        for (int i = 0; i < DEPTH; i++) hold[i] = 0;
        play = 1; loop = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (busy) begin busy_n++; hold[addr]++; end
            if (done) begin done_n++; play = 0; end
        end
        check("oneshot_busy", busy_n, 63);
        check("hold0", hold[0], 11);
        check("hold1", hold[1], 21);
        check("hold2", hold[2], 31);
        check("oneshot_done", done_n, 1);
        check("oneshot_tone", tone, 0);

        // overflow and readback
        do_clear();
        rb = '{8'h51, 8'h52, 8'h53, 8'h54};
        for (int i = 0; i < 4; i++) put(rb[i]);
        put(8'h55);
        check("ovf_count", count, 4);
        check("ovf_full", full, 1);
        check("ovf_flag", ovf, 1);
        tick();
        check("rb0", note, rb[0]);
        for (int i = 1; i < 4; i++) begin
            step = 1; tick(); tick();
            check("rb", note, rb[i]);
        end

        // looping over two notes, then drop play mid-note
        do_clear();
        put(8'h13); put(8'h24);
        play = 1; loop = 1; done_n = 0;
        seq.delete();
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done) done_n++;
            if (busy && (seq.size() == 0 || seq[$] != addr)) seq.push_back(addr);
        end
        check("loop_len", int'(seq.size() >= 4), 1);
        if (seq.size() >= 4) begin
            check("loop_a0", seq[0], 0);
            check("loop_a1", seq[1], 1);
            check("loop_a2", seq[2], 0);
            check("loop_a3", seq[3], 1);
        end
        check("loop_done", done_n, 0);
        play = 0; tick();
        check("stop_busy", busy, 0);
        check("stop_tone", tone, 0);
        loop = 0;

        // rest note and zero-duration note
        do_clear();
        put(8'h10);
        play = 1; busy_n = 0; tone_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_n++;
            if (tone) tone_n++;
            if (done) play = 0;
        end
        check("rest_busy", busy_n, 11);
        check("rest_tone", tone_n, 0);
        do_clear();
        put(8'h05);
        play = 1; busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_n++;
            if (done) play = 0;
        end
        check("dur0_busy", busy_n, 11);

        // manual stepping
        do_clear();
        rb = '{8'hA1, 8'hB2, 8'hC3, 8'h00};
        for (int i = 0; i < 3; i++) put(rb[i]);
        begin
            int ea [4] = '{1, 2, 0, 1};
            for (int i = 0; i < 4; i++) begin
                step = 1; tick();
                check("step_addr", addr, ea[i]);
                tick();
                check("step_note", note, rb[ea[i]]);
            end
        end

        // clear with a write during play
        play = 1; tick(); tick(); tick();
        wr = 1; wbyte = 8'h77; clr = 1; tick();
        check("clr_count", count, 0);
        check("clr_busy", busy, 0);
        check("clr_ovf", ovf, 0);
        play = 0;

        // reset mid-play keeps the buffer
        put(8'h31); put(8'h42);
        play = 1; for (int i = 0; i < 5; i++) tick();
        rst_n = 0; tick();
        check("rst_busy2", busy, 0);
        check("rst_count2", count, 0);
        check("rst_done2", done, 0);
        check("rst_tone2", tone, 0);
        check("rst_buf", note, 8'h31);
        rst_n = 1; play = 0; tick();

        // randomised traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            clr   = ($urandom_range(0, 149) == 0);
            wr    = ($urandom_range(0, 7) == 0);
            wbyte = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            step  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) play = ~play;
            if ($urandom_range(0, 99) == 0) loop = ~loop;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_note_sequencer.md
UART_NOTE_SEQUENCER -- requirements
Module: uart_note_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning note-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter NOTE_CLKS, default 6_250_000, meaning clocks per duration unit (0.25 s at 25 MHz).
REQ-003 SHALL have local constant AW = clog2(DEPTH).
REQ-004 SHALL have port i_Clk, input, 1, meaning the single system clock.
REQ-005 SHALL have port i_Rst_L, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have port i_Wr_DV, input, 1, meaning a one-cycle strobe that writes i_Wr_Byte.
REQ-007 SHALL have port i_Wr_Byte, input, 8, meaning note code: [3:0] pitch index (0 = rest), [7:4] duration units (0 treated as 1).
REQ-008 SHALL have port i_Play, input, 1, meaning a level that enables playback.
REQ-009 SHALL have port i_Loop, input, 1, meaning wrap to entry 0 after the last note.
REQ-010 SHALL have port i_Step, input, 1, meaning a one-cycle pulse that advances the manual address while idle.
REQ-011 SHALL have port i_Clear, input, 1, meaning a one-cycle pulse that empties the buffer.
REQ-012 SHALL have port o_Tone, output, 1, meaning the square-wave audio output.
REQ-013 SHALL have port o_Addr, output, AW, meaning the current read address.
REQ-014 SHALL have port o_Note, output, 8, meaning the byte at o_Addr.
REQ-015 SHALL have port o_Count, output, AW+1, meaning the number of stored notes.
REQ-016 SHALL have port o_Full, output, 1, meaning o_Count == DEPTH.
REQ-017 SHALL have port o_Overflow, output, 1, meaning sticky: a write was dropped while full.
REQ-018 SHALL have port o_Busy, output, 1, meaning the FSM is not IDLE.
REQ-019 SHALL have port o_Done, output, 1, meaning a one-cycle pulse when one-shot playback ends.

Function
REQ-020 Write path: i_Wr_DV && !o_Full -> store at address o_Count and increment o_Count next cycle; i_Wr_DV && o_Full -> drop the byte and set o_Overflow.
REQ-021 Buffer SHALL be synchronous-read memory with 1-cycle read latency; o_Note is valid 1 cycle after o_Addr changes.
REQ-022 FSM states: IDLE, FETCH, PLAY.
REQ-023 IDLE -> FETCH when i_Play && o_Count != 0, with o_Addr = 0.
REQ-024 In FETCH (1 cycle), the module SHALL latch the note, load the duration counter with max(dur,1)*NOTE_CLKS, and load the half-period from the pitch table, then go to PLAY.
REQ-025 In PLAY, o_Tone SHALL toggle each time the half-period counter expires; for pitch 0, o_Tone SHALL be held 0.
REQ-026 When the duration expires in PLAY: if o_Addr < o_Count-1, increment o_Addr and go to FETCH; else if i_Loop, set o_Addr = 0 and go to FETCH; else go to IDLE, pulse o_Done, and set o_Tone = 0.
REQ-027 Writes during playback SHALL be permitted; appended notes are played if reached before the end test of REQ-026.
REQ-028 i_Play low in FETCH/PLAY -> IDLE next cycle, o_Tone = 0, o_Addr retained, no o_Done.
REQ-029 i_Step in IDLE with o_Count != 0 -> o_Addr increments, wrapping to 0 after o_Count-1; i_Step SHALL be ignored when not IDLE or when empty.
REQ-030 i_Clear SHALL take priority over all other actions: o_Count = 0, o_Addr = 0, o_Overflow = 0, FSM -> IDLE, o_Tone = 0; i_Wr_DV in the same cycle is discarded.
REQ-031 i_Play starting from IDLE SHALL restart at address 0.
REQ-032 Counter widths SHALL hold 15*NOTE_CLKS and the largest half-period without overflow.

Reset
REQ-033 On i_Clk edge with i_Rst_L = 0: FSM = IDLE, o_Count = 0, o_Addr = 0, o_Tone = 0, o_Overflow = 0, o_Done = 0, all counters = 0.
REQ-034 Buffer contents SHALL NOT be cleared by reset; reset mid-playback aborts without an o_Done pulse.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding, the 16-entry pitch half-period table (clocks at 25 MHz, C4..D#5, entry 0 unused), and CLK_HZ = 25_000_000.
REQ-036 The note buffer SHALL be one sub-module, note_ram (DEPTH x 8, single write port, registered read port).

Verification (DEPTH=4, NOTE_CLKS=10, scaled pitch table)
REQ-037 Write 0x11,0x22,0x33 then Play with Loop=0 -> addresses 0,1,2 each held 10/20/30 clocks plus 1 FETCH cycle; o_Done pulses once; o_Tone = 0 after.
REQ-038 Write 5 bytes -> o_Count = 4, o_Full = 1, o_Overflow = 1; byte 5 is absent from readback.
REQ-039 Loop=1 with 2 notes -> address sequence 0,1,0,1; no o_Done; drop i_Play mid-note -> IDLE next cycle, o_Tone = 0.
REQ-040 Note 0x10 (rest) -> o_Tone stays 0 for 10 clocks; note with duration 0 -> lasts 10 clocks.
REQ-041 Idle, o_Count = 3, four i_Step pulses -> o_Addr 1,2,0,1; o_Note matches the stored byte 1 cycle later.
REQ-042 i_Clear and i_Wr_DV in the same cycle during PLAY -> o_Count = 0, IDLE, o_Overflow = 0; i_Rst_L low mid-play -> all outputs at their reset values, buffer retained.
